// File: rtl/popcount_pkg.sv
// Shared types and width helpers for the streaming popcount accumulator.
package popcount_pkg;

  typedef enum logic {
    MODE_ONES  = 1'b0,
    MODE_ZEROS = 1'b1
  } mode_e;

  function automatic int cw_f(input int width);
    return $clog2(width) + 1;
  endfunction

  function automatic int aw_f(input int width, input int pkt_max_words);
    return $clog2(width * pkt_max_words) + 1;
  endfunction

endpackage

// File: rtl/popcount_chunk.sv
// Combinational popcount of one CHUNK-bit lane.
module popcount_chunk #(
  parameter  int CHUNK = 4,
  localparam int NW    = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] data_i,
  output logic [NW-1:0]    cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int unsigned i = 0; i < CHUNK; i++) begin
      cnt_o = cnt_o + NW'(data_i[i]);
    end
  end

endmodule

// File: rtl/popcount_stream_accum.sv
// Pipelined per-word popcount (lane counts + pairwise adder tree) with a
// saturating per-packet accumulator and ready/valid backpressure.
module popcount_stream_accum
  import popcount_pkg::*;
#(
  parameter  int WIDTH         = 32,
  parameter  int CHUNK         = 4,
  parameter  int PKT_MAX_WORDS = 256,
  localparam int CW            = cw_f(WIDTH),
  localparam int AW            = aw_f(WIDTH, PKT_MAX_WORDS)
) (
  input  logic             clk,
  input  logic             srst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             data_val_i,
  input  logic             data_last_i,
  input  logic             mode_i,
  output logic             data_ready_o,
  output logic [CW-1:0]    data_o,
  output logic             data_last_o,
  output logic             data_val_o,
  input  logic             ready_i,
  output logic [AW-1:0]    pkt_cnt_o,
  output logic             pkt_sat_o
);

  localparam int unsigned NL = WIDTH / CHUNK;
  localparam int unsigned L  = 1 + $clog2(NL);
  localparam int unsigned NT = 2 * NL - 1;
  localparam int          PW = $clog2(CHUNK) + 1;

  // All tree levels share one flat array: level s starts at 2*NL - 2*(NL>>s).
  function automatic int unsigned off(input int unsigned s);
    return 2 * NL - 2 * (NL >> s);
  endfunction

  logic [CW-1:0]    r_tree [NT];
  logic [L-1:0]     r_val;
  logic [L-1:0]     r_last;
  logic [CW-1:0]    w_cnt  [NL];
  logic [WIDTH-1:0] w_word;
  logic             w_adv;
  mode_e            w_mode;

  assign w_mode = mode_e'(mode_i);
  assign w_word = (w_mode == MODE_ZEROS) ? ~data_i : data_i;

  for (genvar k = 0; k < int'(NL); k++) begin : g_lane
    logic [PW-1:0] w_pc;
    popcount_chunk #(.CHUNK(CHUNK)) u_chunk (
      .data_i (w_word[k*CHUNK +: CHUNK]),
      .cnt_o  (w_pc)
    );
    assign w_cnt[k] = CW'(w_pc);
  end

  assign w_adv        = srst_i | ~r_val[L-1] | ready_i;
  assign data_ready_o = w_adv;

  always_ff @(posedge clk) begin
    if (srst_i) begin
      r_val  <= '0;
      r_last <= '0;
      for (int unsigned i = 0; i < NT; i++) r_tree[i] <= '0;
    end else if (w_adv) begin
      r_val[0]  <= data_val_i;
      r_last[0] <= data_last_i;
      for (int unsigned s = 1; s < L; s++) begin
        r_val[s]  <= r_val[s-1];
        r_last[s] <= r_last[s-1];
      end
      for (int unsigned k = 0; k < NL; k++) r_tree[k] <= w_cnt[k];
      for (int unsigned s = 1; s < L; s++) begin
        for (int unsigned k = 0; k < (NL >> s); k++) begin
          r_tree[off(s)+k] <= r_tree[off(s-1)+2*k] + r_tree[off(s-1)+2*k+1];
        end
      end
    end
  end

  assign data_o      = r_tree[NT-1];
  assign data_val_o  = r_val[L-1];
  assign data_last_o = r_last[L-1];

  logic [AW-1:0] r_acc;
  logic          r_sat;
  logic [AW:0]   w_sum;
  logic          w_clamp;
  logic [AW-1:0] w_pkt;

  assign w_sum     = {1'b0, r_acc} + (AW+1)'(r_tree[NT-1]);
  assign w_clamp   = w_sum[AW];
  assign w_pkt     = w_clamp ? '1 : w_sum[AW-1:0];
  assign pkt_cnt_o = w_pkt;
  assign pkt_sat_o = r_sat | w_clamp;

  always_ff @(posedge clk) begin
    if (srst_i) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (r_val[L-1] && ready_i) begin
      if (r_last[L-1]) begin
        r_acc <= '0;
        r_sat <= 1'b0;
      end else begin
        r_acc <= w_pkt;
        r_sat <= r_sat | w_clamp;
      end
    end
  end

endmodule
